// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects and MUL/DIV FSM encoding.
// Imported by the hazard controller and its forwarding unit.
package pipeline_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle.
// master = pipeline datapath, slave = hazard controller.
interface hazard_controller_if;

   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_UsesRs;
   logic        ID_UsesRt;
   logic        ID_MulDiv;
   logic        ID_UsesHiLo;
   logic        EX_MemRead;
   logic [4:0]  EX_WriteReg;
   logic [4:0]  EX_Rs;
   logic [4:0]  EX_Rt;
   logic        EX_BranchTaken;
   logic        MEM_RegWrite;
   logic [4:0]  MEM_WriteReg;
   logic        WB_RegWrite;
   logic [4:0]  WB_WriteReg;

   logic        PC_Write;
   logic        IFID_Write;
   logic        IFID_Flush;
   logic        IDEX_Bubble;
   logic [1:0]  ForwardA;
   logic [1:0]  ForwardB;
   logic        MulDivBusy;
   logic        MulDivDone;
   logic [31:0] StallCount;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
      output ID_MulDiv, ID_UsesHiLo,
      output EX_MemRead, EX_WriteReg, EX_Rs, EX_Rt,
      output EX_BranchTaken,
      output MEM_RegWrite, MEM_WriteReg,
      output WB_RegWrite, WB_WriteReg,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
      input  ForwardA, ForwardB,
      input  MulDivBusy, MulDivDone, StallCount
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
      input  ID_MulDiv, ID_UsesHiLo,
      input  EX_MemRead, EX_WriteReg, EX_Rs, EX_Rt,
      input  EX_BranchTaken,
      input  MEM_RegWrite, MEM_WriteReg,
      input  WB_RegWrite, WB_WriteReg,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
      output ForwardA, ForwardB,
      output MulDivBusy, MulDivDone, StallCount
   );

endinterface

// File: rtl/forwarding_unit.sv
// EX operand bypass selection from EX/MEM and MEM/WB.
// Pure combinational; the younger EX/MEM result wins over MEM/WB.
module forwarding_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] i_ex_rs,
   input  logic [4:0] i_ex_rt,
   input  logic       i_mem_regwrite,
   input  logic [4:0] i_mem_wreg,
   input  logic       i_wb_regwrite,
   input  logic [4:0] i_wb_wreg,
   output logic [1:0] o_fwd_a,
   output logic [1:0] o_fwd_b
);

   function automatic logic [1:0] sel_src(
      input logic [4:0] src,
      input logic       mem_we,
      input logic [4:0] mem_wr,
      input logic       wb_we,
      input logic [4:0] wb_wr
   );
      logic [1:0] sel;
      sel = FWD_REGFILE;
      // $zero is never bypassed, whatever the writers claim.
      if (src != 5'd0) begin
         if (mem_we && (mem_wr == src))
            sel = FWD_EXMEM;
         else if (wb_we && (wb_wr == src))
            sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   always_comb begin
      o_fwd_a = sel_src(i_ex_rs, i_mem_regwrite, i_mem_wreg,
                        i_wb_regwrite, i_wb_wreg);
      o_fwd_b = sel_src(i_ex_rt, i_mem_regwrite, i_mem_wreg,
                        i_wb_regwrite, i_wb_wreg);
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stall/flush control, EX forwarding,
// MUL/DIV busy window and saturating stall-cycle counter.
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int MULDIV_LATENCY = 32,
   parameter int CNT_W          = 6
)(
   input  logic                CLOCK,
   input  logic                RESET_N,
   hazard_controller_if.slave  hif
);

   md_state_e        r_state;
   md_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic [31:0]      r_stall_cnt;

   logic             w_lu;
   logic             w_md;
   logic             w_issue;
   logic             w_pc_write;
   logic             w_ifid_write;
   logic             w_ifid_flush;
   logic             w_idex_bubble;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   assign w_lu = hif.EX_MemRead
              && (hif.EX_WriteReg != 5'd0)
              && ((hif.ID_UsesRs && (hif.ID_Rs == hif.EX_WriteReg))
               || (hif.ID_UsesRt && (hif.ID_Rt == hif.EX_WriteReg)));

   assign w_md = (r_state == MD_BUSY)
              && (hif.ID_UsesHiLo || hif.ID_MulDiv);

   // A squashed or load-stalled MUL/DIV must not start the unit.
   assign w_issue = (r_state == RUN) && hif.ID_MulDiv
                 && !hif.EX_BranchTaken && !w_lu;

   always_comb begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      priority case (1'b1)
         !RESET_N: begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
         end
         hif.EX_BranchTaken: begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
         end
         (w_lu || w_md): begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
         end
         default: ;
      endcase
   end

   forwarding_unit u_fwd (
      .i_ex_rs        (hif.EX_Rs),
      .i_ex_rt        (hif.EX_Rt),
      .i_mem_regwrite (hif.MEM_RegWrite),
      .i_mem_wreg     (hif.MEM_WriteReg),
      .i_wb_regwrite  (hif.WB_RegWrite),
      .i_wb_wreg      (hif.WB_WriteReg),
      .o_fwd_a        (w_fwd_a),
      .o_fwd_b        (w_fwd_b)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         RUN: begin
            if (w_issue) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = CNT_W'(MULDIV_LATENCY - 1);
            end
         end
         MD_BUSY: begin
            // Branches do not abort: the op left ID already.
            if (r_cnt == '0) begin
               w_state_nxt = RUN;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= RUN;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         if (!w_pc_write && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign hif.PC_Write    = w_pc_write;
   assign hif.IFID_Write  = w_ifid_write;
   assign hif.IFID_Flush  = w_ifid_flush;
   assign hif.IDEX_Bubble = w_idex_bubble;
   assign hif.ForwardA    = RESET_N ? w_fwd_a : FWD_REGFILE;
   assign hif.ForwardB    = RESET_N ? w_fwd_b : FWD_REGFILE;
   assign hif.MulDivBusy  = (r_state == MD_BUSY);
   assign hif.MulDivDone  = r_done;
   assign hif.StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MULDIV_LATENCY=4.
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_hazard_controller;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   hazard_controller_if hif ();

   hazard_controller #(
      .MULDIV_LATENCY (4),
      .CNT_W          (6)
   ) dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .hif     (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr();
      hif.ID_Rs          = 5'd0;
      hif.ID_Rt          = 5'd0;
      hif.ID_UsesRs      = 1'b0;
      hif.ID_UsesRt      = 1'b0;
      hif.ID_MulDiv      = 1'b0;
      hif.ID_UsesHiLo    = 1'b0;
      hif.EX_MemRead     = 1'b0;
      hif.EX_WriteReg    = 5'd0;
      hif.EX_Rs          = 5'd0;
      hif.EX_Rt          = 5'd0;
      hif.EX_BranchTaken = 1'b0;
      hif.MEM_RegWrite   = 1'b0;
      hif.MEM_WriteReg   = 5'd0;
      hif.WB_RegWrite    = 1'b0;
      hif.WB_WriteReg    = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr();
      rst_n = 1'b0;
      hif.MEM_RegWrite = 1'b1;
      hif.MEM_WriteReg = 5'd5;
      hif.EX_Rs        = 5'd5;
      #2;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b0011) begin
         bad++;
         $display("FAIL rst_ctrl got=%b want=0011",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      total++;
      if (hif.ForwardA !== 2'b00) begin
         bad++;
         $display("FAIL rst_fwd got=%b want=00", hif.ForwardA);
      end
      total++;
      if ({hif.MulDivBusy, hif.MulDivDone} !== 2'b00 || hif.StallCount !== 32'd0) begin
         bad++;
         $display("FAIL rst_regs busy=%b done=%b cnt=%0d want 0 0 0",
                  hif.MulDivBusy, hif.MulDivDone, hif.StallCount);
      end
      step();
      clr();
      rst_n = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b1100) begin
         bad++;
         $display("FAIL rst_release got=%b want=1100",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      step();
      total++;
      if (hif.StallCount !== 32'd0) begin
         bad++;
         $display("FAIL rst_cnt got=%0d want=0", hif.StallCount);
      end
   endtask

   task automatic test_load_use();
      clr();
      hif.EX_MemRead  = 1'b1;
      hif.EX_WriteReg = 5'd8;
      hif.ID_Rs       = 5'd8;
      hif.ID_UsesRs   = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b0001) begin
         bad++;
         $display("FAIL lu_rs got=%b want=0001",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      step();
      clr();
      hif.ID_Rs     = 5'd8;
      hif.ID_UsesRs = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IDEX_Bubble} !== 3'b110
          || hif.StallCount !== 32'd1) begin
         bad++;
         $display("FAIL lu_after ctrl=%b cnt=%0d want 110 1",
                  {hif.PC_Write, hif.IFID_Write, hif.IDEX_Bubble}, hif.StallCount);
      end
      clr();
      hif.EX_MemRead  = 1'b1;
      hif.EX_WriteReg = 5'd12;
      hif.ID_Rs       = 5'd3;
      hif.ID_UsesRs   = 1'b1;
      hif.ID_Rt       = 5'd12;
      hif.ID_UsesRt   = 1'b1;
      #1;
      total++;
      if (hif.PC_Write !== 1'b0 || hif.IDEX_Bubble !== 1'b1) begin
         bad++;
         $display("FAIL lu_rt pc=%b bub=%b want 0 1", hif.PC_Write, hif.IDEX_Bubble);
      end
      step();
      clr();
      #1;
      total++;
      if (hif.StallCount !== 32'd2) begin
         bad++;
         $display("FAIL lu_cnt got=%0d want=2", hif.StallCount);
      end
   endtask

   task automatic test_no_stall();
      clr();
      hif.EX_MemRead  = 1'b1;
      hif.EX_WriteReg = 5'd0;
      hif.ID_Rs       = 5'd0;
      hif.ID_UsesRs   = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b1100) begin
         bad++;
         $display("FAIL ns_zero got=%b want=1100",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      hif.EX_WriteReg = 5'd8;
      hif.ID_Rs       = 5'd8;
      hif.ID_UsesRs   = 1'b0;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b1100) begin
         bad++;
         $display("FAIL ns_unused got=%b want=1100",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      step();
      clr();
      #1;
      total++;
      if (hif.StallCount !== 32'd2) begin
         bad++;
         $display("FAIL ns_cnt got=%0d want=2", hif.StallCount);
      end
   endtask

   task automatic test_forwarding();
      clr();
      hif.MEM_RegWrite = 1'b1;
      hif.MEM_WriteReg = 5'd9;
      hif.WB_RegWrite  = 1'b1;
      hif.WB_WriteReg  = 5'd9;
      hif.EX_Rs        = 5'd9;
      #1;
      total++;
      if (hif.ForwardA !== 2'b10) begin
         bad++;
         $display("FAIL fwd_exmem got=%b want=10", hif.ForwardA);
      end
      hif.MEM_RegWrite = 1'b0;
      #1;
      total++;
      if (hif.ForwardA !== 2'b01) begin
         bad++;
         $display("FAIL fwd_memwb got=%b want=01", hif.ForwardA);
      end
      hif.EX_Rs = 5'd0;
      #1;
      total++;
      if (hif.ForwardA !== 2'b00) begin
         bad++;
         $display("FAIL fwd_zero got=%b want=00", hif.ForwardA);
      end
      hif.MEM_RegWrite = 1'b1;
      hif.MEM_WriteReg = 5'd7;
      hif.WB_WriteReg  = 5'd7;
      hif.EX_Rt        = 5'd7;
      hif.EX_Rs        = 5'd6;
      #1;
      total++;
      if (hif.ForwardB !== 2'b10 || hif.ForwardA !== 2'b00) begin
         bad++;
         $display("FAIL fwd_b got=%b/%b want=10/00", hif.ForwardB, hif.ForwardA);
      end
      hif.MEM_WriteReg = 5'd3;
      #1;
      total++;
      if (hif.ForwardB !== 2'b01) begin
         bad++;
         $display("FAIL fwd_b_wb got=%b want=01", hif.ForwardB);
      end
      clr();
   endtask

   task automatic test_muldiv();
      int c0;
      clr();
      c0 = int'(hif.StallCount);
      hif.ID_MulDiv = 1'b1;
      #1;
      total++;
      if (hif.PC_Write !== 1'b1 || hif.MulDivBusy !== 1'b0) begin
         bad++;
         $display("FAIL md_issue pc=%b busy=%b want 1 0", hif.PC_Write, hif.MulDivBusy);
      end
      step();
      hif.ID_MulDiv   = 1'b0;
      hif.ID_UsesHiLo = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (hif.MulDivBusy !== 1'b1 || hif.MulDivDone !== 1'b0
             || hif.PC_Write !== 1'b0 || hif.IDEX_Bubble !== 1'b1) begin
            bad++;
            $display("FAIL md_wait[%0d] busy=%b done=%b pc=%b bub=%b want 1 0 0 1",
                     i, hif.MulDivBusy, hif.MulDivDone, hif.PC_Write, hif.IDEX_Bubble);
         end
         step();
      end
      #1;
      total++;
      if (hif.MulDivBusy !== 1'b0 || hif.MulDivDone !== 1'b1 || hif.PC_Write !== 1'b1
          || hif.StallCount !== 32'(c0 + 4)) begin
         bad++;
         $display("FAIL md_done busy=%b done=%b pc=%b cnt=%0d want 0 1 1 %0d",
                  hif.MulDivBusy, hif.MulDivDone, hif.PC_Write, hif.StallCount, c0 + 4);
      end
      step();
      clr();
      #1;
      total++;
      if (hif.MulDivDone !== 1'b0 || hif.MulDivBusy !== 1'b0) begin
         bad++;
         $display("FAIL md_pulse done=%b busy=%b want 0 0", hif.MulDivDone, hif.MulDivBusy);
      end
   endtask

   task automatic test_back_to_back();
      clr();
      hif.ID_MulDiv = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (hif.PC_Write !== 1'b0) begin
            bad++;
            $display("FAIL b2b_hold[%0d] pc=%b want 0", i, hif.PC_Write);
         end
         step();
      end
      #1;
      total++;
      if (hif.MulDivDone !== 1'b1 || hif.PC_Write !== 1'b1) begin
         bad++;
         $display("FAIL b2b_issue done=%b pc=%b want 1 1", hif.MulDivDone, hif.PC_Write);
      end
      step();
      hif.ID_MulDiv = 1'b0;
      hif.EX_BranchTaken = 1'b1;
      #1;
      total++;
      if (hif.MulDivBusy !== 1'b1 || hif.IFID_Flush !== 1'b1 || hif.PC_Write !== 1'b1) begin
         bad++;
         $display("FAIL b2b_busy busy=%b flush=%b pc=%b want 1 1 1",
                  hif.MulDivBusy, hif.IFID_Flush, hif.PC_Write);
      end
      step();
      hif.EX_BranchTaken = 1'b0;
      step();
      step();
      #1;
      total++;
      if (hif.MulDivBusy !== 1'b1 || hif.MulDivDone !== 1'b0) begin
         bad++;
         $display("FAIL b2b_nobort busy=%b done=%b want 1 0", hif.MulDivBusy, hif.MulDivDone);
      end
      step();
      total++;
      if (hif.MulDivBusy !== 1'b0 || hif.MulDivDone !== 1'b1) begin
         bad++;
         $display("FAIL b2b_end busy=%b done=%b want 0 1", hif.MulDivBusy, hif.MulDivDone);
      end
      step();
   endtask

   task automatic test_branch_priority();
      int c0;
      clr();
      c0 = int'(hif.StallCount);
      hif.EX_MemRead     = 1'b1;
      hif.EX_WriteReg    = 5'd8;
      hif.ID_Rs          = 5'd8;
      hif.ID_UsesRs      = 1'b1;
      hif.EX_BranchTaken = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b1111) begin
         bad++;
         $display("FAIL br_prio got=%b want=1111",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      step();
      clr();
      #1;
      total++;
      if (hif.StallCount !== 32'(c0)) begin
         bad++;
         $display("FAIL br_cnt got=%0d want=%0d", hif.StallCount, c0);
      end
   endtask

   task automatic test_reset_mid_busy();
      clr();
      hif.ID_MulDiv = 1'b1;
      step();
      hif.ID_MulDiv = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if (hif.MulDivBusy !== 1'b0 || hif.StallCount !== 32'd0
          || hif.PC_Write !== 1'b0 || hif.IFID_Flush !== 1'b1) begin
         bad++;
         $display("FAIL rmb_async busy=%b cnt=%0d pc=%b flush=%b want 0 0 0 1",
                  hif.MulDivBusy, hif.StallCount, hif.PC_Write, hif.IFID_Flush);
      end
      step();
      rst_n = 1'b1;
      #1;
      total++;
      if ({hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble} !== 4'b1100) begin
         bad++;
         $display("FAIL rmb_release got=%b want=1100",
                  {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble});
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (hif.MulDivBusy !== 1'b0 || hif.MulDivDone !== 1'b0
             || hif.StallCount !== 32'd0) begin
            bad++;
            $display("FAIL rmb_idle[%0d] busy=%b done=%b cnt=%0d want 0 0 0",
                     i, hif.MulDivBusy, hif.MulDivDone, hif.StallCount);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clr();
      test_reset();
      test_load_use();
      test_no_stall();
      test_forwarding();
      test_muldiv();
      test_back_to_back();
      test_branch_priority();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
